// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter
//   Gives one shared bus to N requesters in round-robin order. Each grant goes
//   through a BUSY / WAIT / FREE sequence. done ends a transfer, and dly can
//   stretch the hold after done. A hold-time watchdog can force the bus free.
//   FREE is a one-cycle turnaround with no owner before the next grant.
//   Every output is registered.
//
// Parameters
//   N         number of requesters (2..16)
//   MAX_HOLD  maximum cycles in BBUSY before a forced release; 0 disables it
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   req      in   [N] per-requester level request
//   done     in   current owner has finished its transfer
//   dly      in   owner needs extra hold cycles after done
//   gnt      out  [N] one-hot grant
//   gnt_id   out  encoded owner, valid while busy is high, otherwise 0
//   busy     out  high in BBUSY or BWAIT
//   timeout  out  one-cycle pulse when the watchdog forced the release
module bus_rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 done,
  input  logic                 dly,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 timeout
);

  localparam int IDW = $clog2(N);
  // Keep hold_cnt at least one bit wide so the design still builds when the
  // watchdog is disabled.
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int LIMIT_INT = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic [HW-1:0] HOLD_LIMIT = HW'(LIMIT_INT);
  localparam logic [HW-1:0] HOLD_MAX   = '1;
  localparam logic [N-1:0]  ONE        = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BBUSY = 2'd1,
    BWAIT = 2'd2,
    BFREE = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [IDW-1:0]  owner, owner_n;
  logic [IDW-1:0]  last, last_n;
  logic [HW-1:0]   hold_cnt, hold_n;
  logic [N-1:0]    gnt_n;
  logic [IDW-1:0]  gnt_id_n;
  logic            busy_n, timeout_n;
  logic [IDW-1:0]  base, win;

  // Round-robin search. It starts one past base and wraps around. Base itself
  // is checked last, so the previous owner wins only when it is the sole
  // requester.
  function automatic logic [IDW-1:0] pick(input logic [N-1:0] r,
                                          input logic [IDW-1:0] b);
    logic found;
    int   idx;
    pick  = b;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(b) + i) % N;
      if (!found && r[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  endfunction

  // In BFREE the owner that is being released has not yet been copied into
  // last. Its index is used directly as the search base.
  always_comb begin
    base = (state == BFREE) ? owner : last;
    win  = pick(req, base);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state;
    owner_n   = owner;
    last_n    = last;
    hold_n    = hold_cnt;
    gnt_n     = gnt;
    gnt_id_n  = gnt_id;
    busy_n    = busy;
    timeout_n = 1'b0;

    unique case (state)
      IDLE: begin
        if (|req) begin
          state_n  = BBUSY;
          owner_n  = win;
          gnt_n    = ONE << win;
          gnt_id_n = win;
          busy_n   = 1'b1;
          hold_n   = '0;
        end
      end

      BBUSY: begin
        if (hold_cnt != HOLD_MAX) hold_n = hold_cnt + 1'b1;
        if (done && dly) begin
          state_n = BWAIT;
        end else if (done || ((MAX_HOLD != 0) && (hold_cnt == HOLD_LIMIT))) begin
          // done takes priority over the watchdog. A release caused by done
          // on the limit cycle is a normal release and raises no timeout.
          state_n   = BFREE;
          gnt_n     = '0;
          gnt_id_n  = '0;
          busy_n    = 1'b0;
          timeout_n = !done;
        end
      end

      BWAIT: begin
        if (!dly) begin
          state_n  = BFREE;
          gnt_n    = '0;
          gnt_id_n = '0;
          busy_n   = 1'b0;
        end
      end

      BFREE: begin
        last_n = owner;
        if (|req) begin
          state_n  = BBUSY;
          owner_n  = win;
          gnt_n    = ONE << win;
          gnt_id_n = win;
          busy_n   = 1'b1;
          hold_n   = '0;
        end else begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // State and output registers. Reset drops the grant immediately, including
  // in the middle of a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      last     <= IDW'(N - 1);
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      last     <= last_n;
      hold_cnt <= hold_n;
      gnt      <= gnt_n;
      gnt_id   <= gnt_id_n;
      busy     <= busy_n;
      timeout  <= timeout_n;
    end
  end

endmodule
